// File: rtl/wb_arbiter.sv
// wb_arbiter: merges S0 (write visible 1 cycle after accept) and FIFO-queued S1 (2 cycles) onto one registered RF write port.
// Backpressure: S0 stalls only on a starvation-forced S1 grant, S1 stalls when the FIFO is full; WB_COMMIT_CNT_EN adds commit_cnt_o.
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s0_valid_i,
  output logic        s0_ready_o,
  input  logic [4:0]  s0_rd_addr_i,
  input  logic [31:0] s0_rd_data_i,
  input  logic        s1_valid_i,
  output logic        s1_ready_o,
  input  logic [4:0]  s1_rd_addr_i,
  input  logic [31:0] s1_rd_data_i,
  output logic        write_en_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        idle_o,
  output logic [31:0] commit_cnt_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    q_addr [FIFO_DEPTH];
  logic [31:0]   q_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic        empty;
  logic        full;
  logic        force_head;
  logic        grant_s0;
  logic        grant_s1;
  logic        grant_any;
  logic        push;
  logic [4:0]  grant_addr;
  logic [31:0] grant_data;

  assign empty      = (count == '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign force_head = (starve_cnt == SW'(STARVE_LIMIT)) && !empty;
  assign grant_s0   = s0_valid_i && !force_head;
  assign grant_s1   = !grant_s0 && !empty;
  assign grant_any  = grant_s0 || grant_s1;
  // Full blocks enqueue even when a pop happens in the same cycle.
  assign push       = s1_valid_i && !full;

  assign s0_ready_o = !force_head;
  assign s1_ready_o = !full;
  assign idle_o     = empty && !write_en_o;

  always_comb begin
    grant_addr = q_addr[rd_ptr];
    grant_data = q_data[rd_ptr];
    if (grant_s0) begin
      grant_addr = s0_rd_addr_i;
      grant_data = s0_rd_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_addr[wr_ptr] <= s1_rd_addr_i;
      q_data[wr_ptr] <= s1_rd_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (grant_s1) rd_ptr <= rd_ptr + AW'(1);
      case ({push, grant_s1})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (empty || grant_s1) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // x0 results are consumed like any other but never raise write_en_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_en_o <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
    end else if (grant_any) begin
      write_en_o <= (grant_addr != 5'd0);
      rd_addr_o  <= grant_addr;
      rd_data_o  <= grant_data;
    end else begin
      write_en_o <= 1'b0;
    end
  end

`ifdef WB_COMMIT_CNT_EN
  logic [31:0] commit_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      commit_cnt <= '0;
    end else if (grant_any && (grant_addr != 5'd0)) begin
      commit_cnt <= commit_cnt + 32'd1;
    end
  end

  assign commit_cnt_o = commit_cnt;
`else
  assign commit_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios then random traffic against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        s0_valid_i = 1'b0;
  logic        s0_ready_o;
  logic [4:0]  s0_rd_addr_i = '0;
  logic [31:0] s0_rd_data_i = '0;
  logic        s1_valid_i = 1'b0;
  logic        s1_ready_o;
  logic [4:0]  s1_rd_addr_i = '0;
  logic [31:0] s1_rd_data_i = '0;
  logic        write_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        idle_o;
  logic [31:0] commit_cnt_o;

  int total = 0;
  int bad = 0;

  // Reference model: pending S1 results in arrival order, plus how long the head has waited.
  bit [36:0]   q[$];
  int          streak;
  bit          exp_we;
  bit [4:0]    exp_addr;
  bit [31:0]   exp_data;
  bit [31:0]   exp_cnt;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s0_valid_i(s0_valid_i), .s0_ready_o(s0_ready_o),
    .s0_rd_addr_i(s0_rd_addr_i), .s0_rd_data_i(s0_rd_data_i),
    .s1_valid_i(s1_valid_i), .s1_ready_o(s1_ready_o),
    .s1_rd_addr_i(s1_rd_addr_i), .s1_rd_data_i(s1_rd_data_i),
    .write_en_o(write_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .idle_o(idle_o), .commit_cnt_o(commit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit [31:0] cnt_exp();
`ifdef WB_COMMIT_CNT_EN
    return exp_cnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s0_valid_i = 1'b1; s0_rd_addr_i = 5'($urandom_range(1, 31)); s0_rd_data_i = $urandom;
      s1_valid_i = 1'b1; s1_rd_addr_i = 5'($urandom_range(1, 31)); s1_rd_data_i = $urandom;
      @(posedge clk_i); #1;
      chk("rst_we", {31'b0, write_en_o}, 32'd0);
      chk("rst_addr", {27'b0, rd_addr_o}, 32'd0);
      chk("rst_data", rd_data_o, 32'd0);
      chk("rst_cnt", commit_cnt_o, 32'd0);
      @(negedge clk_i);
    end
    chk("rst_s0_ready", {31'b0, s0_ready_o}, 32'd1);
    chk("rst_s1_ready", {31'b0, s1_ready_o}, 32'd1);
    chk("rst_idle", {31'b0, idle_o}, 32'd1);
    rst_i = 1'b0;
    s0_valid_i = 1'b0;
    s1_valid_i = 1'b0;
    q.delete();
    streak = 0; exp_we = 0; exp_addr = 0; exp_data = 0; exp_cnt = 0;
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step(input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                      input bit v1, input bit [4:0] a1, input bit [31:0] d1);
    bit frc, g0, g1, acc1;
    int sz;
    bit [36:0] e;
    s0_valid_i = v0; s0_rd_addr_i = a0; s0_rd_data_i = d0;
    s1_valid_i = v1; s1_rd_addr_i = a1; s1_rd_data_i = d1;
    #1;
    sz   = q.size();
    frc  = (streak >= LIMIT) && (sz != 0);
    chk("s0_ready", {31'b0, s0_ready_o}, {31'b0, !frc});
    chk("s1_ready", {31'b0, s1_ready_o}, {31'b0, sz < DEPTH});
    chk("idle", {31'b0, idle_o}, {31'b0, (sz == 0) && !exp_we});
    g0   = v0 && !frc;
    g1   = !g0 && (sz != 0);
    acc1 = v1 && (sz < DEPTH);
    if (g0) begin
      exp_addr = a0; exp_data = d0; exp_we = (a0 != 0);
    end else if (g1) begin
      e = q.pop_front();
      exp_addr = e[36:32]; exp_data = e[31:0]; exp_we = (e[36:32] != 0);
    end else begin
      exp_we = 0;
    end
    if (exp_we) exp_cnt = exp_cnt + 1;
    if (sz == 0 || g1) streak = 0;
    else if (streak < LIMIT) streak++;
    if (acc1) q.push_back({a1, d1});
    @(posedge clk_i); #1;
    chk("write_en", {31'b0, write_en_o}, {31'b0, exp_we});
    chk("rd_addr", {27'b0, rd_addr_o}, {27'b0, exp_addr});
    chk("rd_data", rd_data_o, exp_data);
    chk("commit_cnt", commit_cnt_o, cnt_exp());
    @(negedge clk_i);
  endtask

  initial begin
    int pushed;
    int cyc;
    bit [31:0] cnt_before;
    @(negedge clk_i);
    do_reset();

    // S0 only
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    chk("s0_we", {31'b0, write_en_o}, 32'd1);
    chk("s0_addr", {27'b0, rd_addr_o}, 32'd5);
    chk("s0_data", rd_data_o, 32'hDEADBEEF);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("s0_we_drop", {31'b0, write_en_o}, 32'd0);

    // S1 only: visible two edges after enqueue
    step(0, 5'd0, 32'd0, 1, 5'd7, 32'h12345678);
    chk("s1_we_n1", {31'b0, write_en_o}, 32'd0);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("s1_we_n2", {31'b0, write_en_o}, 32'd1);
    chk("s1_addr", {27'b0, rd_addr_o}, 32'd7);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("s1_we_n3", {31'b0, write_en_o}, 32'd0);

    // Starvation: S0 held valid, one S1 entry
    step(1, 5'd10, 32'hA0, 1, 5'd9, 32'h99);
    for (int k = 1; k <= LIMIT; k++) begin
      step(1, 5'(10 + k), 32'hA0 + k, 0, 5'd0, 32'd0);
      chk("starve_s0_addr", {27'b0, rd_addr_o}, 32'(10 + k));
    end
    #1;
    chk("starve_force", {31'b0, s0_ready_o}, 32'd0);
    step(1, 5'd15, 32'hA5, 0, 5'd0, 32'd0);
    chk("starve_head", {27'b0, rd_addr_o}, 32'd9);
    step(1, 5'd15, 32'hA5, 0, 5'd0, 32'd0);
    chk("starve_resume", {27'b0, rd_addr_o}, 32'd15);

    // Full FIFO with S0 saturating; entries rd=1..5 retire in order
    pushed = 1;
    cyc = 0;
    while (pushed <= 5 && cyc < 60) begin
      if (s1_ready_o) begin
        step(1, 5'd20, 32'hB0 + cyc, 1, 5'(pushed), 32'h111 * pushed);
        pushed++;
      end else begin
        step(1, 5'd20, 32'hB0 + cyc, 1, 5'd6, 32'h666);
      end
      cyc++;
    end
    chk("full_all_pushed", 32'(pushed), 32'd6);
    for (int k = 0; k < 8; k++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("full_drained_idle", {31'b0, idle_o}, 32'd1);

    // x0 writes are consumed silently
    cnt_before = commit_cnt_o;
    step(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0);
    chk("x0_we", {31'b0, write_en_o}, 32'd0);
    chk("x0_cnt_same", commit_cnt_o, cnt_before);
    step(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
`ifdef WB_COMMIT_CNT_EN
    chk("x0_cnt_inc", commit_cnt_o, cnt_before + 32'd1);
`else
    chk("x0_cnt_tied", commit_cnt_o, 32'd0);
`endif

    // Random traffic, including x0 destinations and a mid-stream reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step($urandom_range(0, 9) < 6, 5'($urandom), $urandom,
           $urandom_range(0, 9) < 4, 5'($urandom), $urandom);
    end
    for (int k = 0; k < 10; k++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("final_idle", {31'b0, idle_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
